// File: rtl/tile_stream_pkg.sv
// Shared definitions for the tile request stream: word layout, type codes,
// serializer FSM encoding and a word-packing helper.
package tile_stream_pkg;

   localparam int WORD_WIDTH    = 32;
   localparam int TYPE_LSB      = 29;
   localparam int PAYLOAD_WIDTH = 29;

   localparam logic [2:0] WORD_TYPE_ADDR   = 3'd0;
   localparam logic [2:0] WORD_TYPE_ZOOM   = 3'd1;
   localparam logic [2:0] WORD_TYPE_C_REAL = 3'd2;
   localparam logic [2:0] WORD_TYPE_C_IMAG = 3'd3;
   localparam logic [2:0] WORD_TYPE_END    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ZOOM,
      ST_REAL,
      ST_IMAG,
      ST_END
   } state_t;

   // Packs a type code and payload into one stream word.
   function automatic logic [WORD_WIDTH-1:0] make_word(input logic [2:0]               word_type,
                                                      input logic [PAYLOAD_WIDTH-1:0] payload);
      logic [WORD_WIDTH-1:0] word;
      word                          = '0;
      word[WORD_WIDTH-1:TYPE_LSB]   = word_type;
      word[TYPE_LSB-1:0]            = payload;
      return word;
   endfunction

endpackage

// File: rtl/limb_buffer.sv
// Two limb register files (c_real, c_imag) with one synchronous write port
// and one combinational read port, so the serializer streams without bubbles.
module limb_buffer #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int LIMB_SIZE_BITS  = 8
) (
   input  logic                       clock,
   input  logic                       wr_en,
   input  logic                       wr_sel,
   input  logic [LIMB_INDEX_BITS-1:0] wr_index,
   input  logic [LIMB_SIZE_BITS-1:0]  wr_data,
   input  logic                       rd_sel,
   input  logic [LIMB_INDEX_BITS-1:0] rd_index,
   output logic [LIMB_SIZE_BITS-1:0]  rd_data
);

   localparam int DEPTH = 1 << LIMB_INDEX_BITS;

   logic [LIMB_SIZE_BITS-1:0] real_mem [DEPTH];
   logic [LIMB_SIZE_BITS-1:0] imag_mem [DEPTH];

   // Store one limb into the selected coordinate buffer.
   // NOTE: storage arrays carry no reset; clearing them would cost a reset
   // fan-out to every bit and the host always loads limbs before a job.
   always_ff @(posedge clock) begin
      if (wr_en && !wr_sel) real_mem[wr_index] <= wr_data;
      if (wr_en &&  wr_sel) imag_mem[wr_index] <= wr_data;
   end

   assign rd_data = rd_sel ? imag_mem[rd_index] : real_mem[rd_index];

endmodule

// File: rtl/tile_request_serializer.sv
// Serializes one tile request (address, zoom, c_real limbs, c_imag limbs,
// end marker) into typed 32-bit words over a registered valid/ready port.
module tile_request_serializer #(
   parameter int LIMB_INDEX_BITS = 6,
   parameter int LIMB_SIZE_BITS  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic                       wr_sel,
   input  logic [LIMB_INDEX_BITS-1:0] wr_index,
   input  logic [LIMB_SIZE_BITS-1:0]  wr_data,
   output logic                       wr_ready,
   input  logic                       start,
   input  logic [28:0]                start_address,
   input  logic [7:0]                 start_zoom,
   input  logic [LIMB_INDEX_BITS:0]   start_limb_count,
   output logic                       busy,
   output logic                       done,
   output logic                       out_valid,
   output logic [31:0]                out_data,
   output logic                       out_end_of_stream,
   input  logic                       out_ready
);

   import tile_stream_pkg::*;

   localparam logic [LIMB_INDEX_BITS:0]   MAX_COUNT = {1'b1, {LIMB_INDEX_BITS{1'b0}}};
   localparam logic [LIMB_INDEX_BITS:0]   COUNT_ONE = 1;
   localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE   = 1;

   state_t                     state_q,     state_d;
   logic [7:0]                 zoom_q,      zoom_d;
   logic [LIMB_INDEX_BITS:0]   count_q,     count_d;
   logic [LIMB_INDEX_BITS-1:0] idx_q,       idx_d;
   logic                       out_valid_q, out_valid_d;
   logic [WORD_WIDTH-1:0]      out_data_q,  out_data_d;
   logic                       eos_q,       eos_d;
   logic                       done_q,      done_d;

   logic                       rd_sel;
   logic [LIMB_INDEX_BITS-1:0] rd_index;
   logic [LIMB_SIZE_BITS-1:0]  rd_data;
   logic                       xfer;
   logic                       last_limb;
   logic [PAYLOAD_WIDTH-1:0]   limb_payload;

   assign busy      = (state_q != ST_IDLE);
   assign wr_ready  = !busy;
   assign xfer      = out_valid_q && out_ready;
   assign last_limb = ({1'b0, idx_q} == (count_q - COUNT_ONE));

   limb_buffer #(
      .LIMB_INDEX_BITS (LIMB_INDEX_BITS),
      .LIMB_SIZE_BITS  (LIMB_SIZE_BITS)
   ) u_limb_buffer (
      .clock    (clock),
      .wr_en    (wr_en && wr_ready),
      .wr_sel   (wr_sel),
      .wr_index (wr_index),
      .wr_data  (wr_data),
      .rd_sel   (rd_sel),
      .rd_index (rd_index),
      .rd_data  (rd_data)
   );

   assign limb_payload = PAYLOAD_WIDTH'(rd_data);

   // Read address of the limb that follows the word currently on the port.
   always_comb begin
      rd_sel   = 1'b0;
      rd_index = '0;
      case (state_q)
         ST_REAL: begin
            rd_sel   = last_limb;
            rd_index = last_limb ? '0 : idx_q + IDX_ONE;
         end
         ST_IMAG: begin
            rd_sel   = 1'b1;
            rd_index = idx_q + IDX_ONE;
         end
         default: ;
      endcase
   end

   // Next-state and next-word logic; a new word is loaded only on a transfer.
   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      zoom_d      = zoom_q;
      count_d     = count_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      eos_d       = eos_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ADDR;
               zoom_d      = start_zoom;
               count_d     = (start_limb_count > MAX_COUNT) ? MAX_COUNT : start_limb_count;
               idx_d       = '0;
               out_valid_d = 1'b1;
               out_data_d  = make_word(WORD_TYPE_ADDR, start_address);
               eos_d       = 1'b0;
            end
         end
         ST_ADDR: begin
            if (xfer) begin
               state_d    = ST_ZOOM;
               out_data_d = make_word(WORD_TYPE_ZOOM, PAYLOAD_WIDTH'(zoom_q));
            end
         end
         ST_ZOOM: begin
            if (xfer) begin
               if (count_q != '0) begin
                  state_d    = ST_REAL;
                  idx_d      = '0;
                  out_data_d = make_word(WORD_TYPE_C_REAL, limb_payload);
               end else begin
                  state_d    = ST_END;
                  out_data_d = make_word(WORD_TYPE_END, '0);
                  eos_d      = 1'b1;
               end
            end
         end
         ST_REAL: begin
            if (xfer) begin
               if (last_limb) begin
                  state_d    = ST_IMAG;
                  idx_d      = '0;
                  out_data_d = make_word(WORD_TYPE_C_IMAG, limb_payload);
               end else begin
                  idx_d      = idx_q + IDX_ONE;
                  out_data_d = make_word(WORD_TYPE_C_REAL, limb_payload);
               end
            end
         end
         ST_IMAG: begin
            if (xfer) begin
               if (last_limb) begin
                  state_d    = ST_END;
                  out_data_d = make_word(WORD_TYPE_END, '0);
                  eos_d      = 1'b1;
               end else begin
                  idx_d      = idx_q + IDX_ONE;
                  out_data_d = make_word(WORD_TYPE_C_IMAG, limb_payload);
               end
            end
         end
         ST_END: begin
            if (xfer) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               eos_d       = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         zoom_q      <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         eos_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         zoom_q      <= zoom_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         eos_q       <= eos_d;
         done_q      <= done_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_end_of_stream = eos_q;
   assign done              = done_q;

endmodule

// File: tb/tb_tile_request_serializer.sv
// Directed bench for tile_request_serializer: hand-computed word sequences
// for normal, backpressured, empty, busy-protected, reset and full-size jobs.
module tb_tile_request_serializer;

   logic        clock;
   logic        reset;
   logic        wr_en;
   logic        wr_sel;
   logic [5:0]  wr_index;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        start;
   logic [28:0] start_address;
   logic [7:0]  start_zoom;
   logic [6:0]  start_limb_count;
   logic        busy;
   logic        done;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_end_of_stream;
   logic        out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   tile_request_serializer dut (
      .clock             (clock),
      .reset             (reset),
      .wr_en             (wr_en),
      .wr_sel            (wr_sel),
      .wr_index          (wr_index),
      .wr_data           (wr_data),
      .wr_ready          (wr_ready),
      .start             (start),
      .start_address     (start_address),
      .start_zoom        (start_zoom),
      .start_limb_count  (start_limb_count),
      .busy              (busy),
      .done              (done),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_end_of_stream (out_end_of_stream),
      .out_ready         (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_limb(input logic sel, input logic [5:0] idx, input logic [7:0] data);
      wr_en    = 1'b1;
      wr_sel   = sel;
      wr_index = idx;
      wr_data  = data;
      step();
      wr_en    = 1'b0;
   endtask

   task automatic start_job(input logic [28:0] addr, input logic [7:0] zoom, input logic [6:0] count);
      start            = 1'b1;
      start_address    = addr;
      start_zoom       = zoom;
      start_limb_count = count;
      step();
      start            = 1'b0;
   endtask

   // Expects exp_q word by word starting on the current cycle. stall_at holds
   // out_ready low for stall_cycles before that word transfers; intrude_at
   // fires a start and a limb write while that word is on the port.
   task automatic run_expect(input string tag, input logic [31:0] exp_q[$],
                             input int stall_at, input int stall_cycles, input int intrude_at);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               check($sformatf("%s_hold%0d_valid", tag, s), {31'd0, out_valid}, 32'd1);
               check($sformatf("%s_hold%0d_data", tag, s), out_data, exp_q[i]);
               step();
            end
            out_ready = 1'b1;
         end
         check($sformatf("%s_w%0d_valid", tag, i), {31'd0, out_valid}, 32'd1);
         check($sformatf("%s_w%0d_data", tag, i), out_data, exp_q[i]);
         check($sformatf("%s_w%0d_eos", tag, i), {31'd0, out_end_of_stream},
               (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
         if (i == intrude_at) begin
            check($sformatf("%s_wr_ready_busy", tag), {31'd0, wr_ready}, 32'd0);
            start            = 1'b1;
            start_address    = 29'd9;
            start_limb_count = 7'd1;
            wr_en            = 1'b1;
            wr_sel           = 1'b0;
            wr_index         = 6'd0;
            wr_data          = 8'hAA;
         end
         step();
         start = 1'b0;
         wr_en = 1'b0;
      end
      check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
      check($sformatf("%s_idle_busy", tag), {31'd0, busy}, 32'd0);
      check($sformatf("%s_idle_valid", tag), {31'd0, out_valid}, 32'd0);
      step();
      check($sformatf("%s_done_drop", tag), {31'd0, done}, 32'd0);
   endtask

   logic [31:0] exp_q[$];

   initial begin
      reset            = 1'b1;
      wr_en            = 1'b0;
      wr_sel           = 1'b0;
      wr_index         = '0;
      wr_data          = '0;
      start            = 1'b0;
      start_address    = '0;
      start_zoom       = '0;
      start_limb_count = '0;
      out_ready        = 1'b1;
      step();
      step();
      check("rst_busy",     {31'd0, busy},              32'd0);
      check("rst_done",     {31'd0, done},              32'd0);
      check("rst_valid",    {31'd0, out_valid},         32'd0);
      check("rst_data",     out_data,                   32'd0);
      check("rst_eos",      {31'd0, out_end_of_stream}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_ready},          32'd1);
      reset = 1'b0;
      step();

      // Job 1: three limbs per coordinate, no stalls.
      for (int i = 0; i < 3; i++) begin
         write_limb(1'b0, 6'(i), 8'(3 + i));
         write_limb(1'b1, 6'(i), 8'(6 + i));
      end
      start_job(29'd1, 8'd2, 7'd3);
      check("job1_busy", {31'd0, busy}, 32'd1);
      exp_q = '{32'h00000001, 32'h20000002, 32'h40000003, 32'h40000004, 32'h40000005,
                32'h60000006, 32'h60000007, 32'h60000008, 32'h80000000};
      run_expect("job1", exp_q, -1, 0, -1);

      // Same job with a 3-cycle stall on 0x60000007.
      start_job(29'd1, 8'd2, 7'd3);
      run_expect("bp", exp_q, 6, 3, -1);

      // No limbs: address, zoom, end only; payload extremes.
      start_job(29'h1FFFFFFF, 8'd255, 7'd0);
      exp_q = '{32'h1FFFFFFF, 32'h200000FF, 32'h80000000};
      run_expect("cnt0", exp_q, -1, 0, -1);

      // Start and limb write during a job are ignored.
      start_job(29'h11, 8'd1, 7'd3);
      exp_q = '{32'h00000011, 32'h20000001, 32'h40000003, 32'h40000004, 32'h40000005,
                32'h60000006, 32'h60000007, 32'h60000008, 32'h80000000};
      run_expect("busy", exp_q, -1, 0, 1);
      start_job(29'h12, 8'd0, 7'd1);
      exp_q = '{32'h00000012, 32'h20000000, 32'h40000003, 32'h60000006, 32'h80000000};
      run_expect("oldreal", exp_q, -1, 0, -1);

      // Start and limb write together in idle: the job sees the new limb.
      wr_en    = 1'b1;
      wr_sel   = 1'b0;
      wr_index = 6'd0;
      wr_data  = 8'h10;
      start_job(29'h22, 8'd3, 7'd1);
      wr_en    = 1'b0;
      exp_q = '{32'h00000022, 32'h20000003, 32'h40000010, 32'h60000006, 32'h80000000};
      run_expect("simul", exp_q, -1, 0, -1);

      // Reset while a c_real limb is on the port.
      start_job(29'd5, 8'd6, 7'd3);
      step();
      step();
      check("rstmid_pre_data", out_data, 32'h40000010);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_valid", {31'd0, out_valid}, 32'd0);
      check("rstmid_busy",  {31'd0, busy},      32'd0);
      step();
      reset = 1'b0;
      step();
      check("rstmid_no_done", {31'd0, done}, 32'd0);
      start_job(29'd5, 8'd6, 7'd3);
      exp_q = '{32'h00000005, 32'h20000006, 32'h40000010, 32'h40000004, 32'h40000005,
                32'h60000006, 32'h60000007, 32'h60000008, 32'h80000000};
      run_expect("rstnew", exp_q, -1, 0, -1);

      // Full buffers: limb[i] = i in both coordinates.
      for (int i = 0; i < 64; i++) begin
         write_limb(1'b0, 6'(i), 8'(i));
         write_limb(1'b1, 6'(i), 8'(i));
      end
      exp_q = '{32'h00000003, 32'h20000004};
      for (int i = 0; i < 64; i++) exp_q.push_back(32'h40000000 | 32'(i));
      for (int i = 0; i < 64; i++) exp_q.push_back(32'h60000000 | 32'(i));
      exp_q.push_back(32'h80000000);
      check("max_len", 32'(exp_q.size()), 32'd131);
      start_job(29'd3, 8'd4, 7'd64);
      run_expect("max", exp_q, -1, 0, -1);

      // Count above the buffer depth is clamped to 64.
      start_job(29'd3, 8'd4, 7'd100);
      run_expect("clamp", exp_q, 70, 2, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
